icache_refill: RTL

- Fetch-side controller that acts as the initiator for the 16-line direct-mapped instruction cache.
- Accepts one word-aligned fetch request at a time from the core and presents the address to the cache for lookup.
- On a hit it returns the cached word to the core.
- On a miss it fetches the word over a valid/ready memory bus, writes it into the cache, then returns it to the core.

---
 rtl/icache_refill.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Fetch-side refill controller for a 16-line direct-mapped instruction cache.
// Define ICACHE_REFILL_PERF_EN to add saturating hit/miss/timeout counters.
module icache_refill #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          CACHE_EN       = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [29:0] ic_addr,
    output logic        ic_wen,
    output logic [31:0] ic_wdata,
    input  logic        ic_is_hit,
    input  logic [31:0] ic_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [15:0] perf_timeouts
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StMemWait,
        StFill,
        StResp
    } state_e;

    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [15:0] tmo_cnt_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        mem_req_valid_q;
    logic        ic_wen_q;

    logic lookup_hit;
    logic tmo_expire;

    assign lookup_hit = ic_is_hit & CACHE_EN;
    // A response in the final wait cycle takes priority over the timeout.
    assign tmo_expire = (state_q == StMemWait) & ~mem_rsp_valid & (tmo_cnt_q == TmoLast);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            data_q          <= '0;
            tmo_cnt_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            ic_wen_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (lookup_hit) begin
                        data_q      <= ic_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        state_q         <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        tmo_cnt_q       <= '0;
                        state_q         <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (mem_rsp_valid) begin
                        data_q   <= mem_rdata;
                        ic_wen_q <= CACHE_EN;
                        state_q  <= StFill;
                    end else if (tmo_expire) begin
                        data_q      <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                StFill: begin
                    ic_wen_q    <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = data_q;
    assign rsp_err       = rsp_err_q;
    assign ic_addr       = addr_q;
    assign ic_wen        = ic_wen_q;
    assign ic_wdata      = data_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = {addr_q, 2'b00};

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_hits_q;
    logic [31:0] perf_misses_q;
    logic [15:0] perf_timeouts_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_hits_q     <= '0;
            perf_misses_q   <= '0;
            perf_timeouts_q <= '0;
        end else begin
            if (state_q == StLookup) begin
                if (lookup_hit && perf_hits_q != '1) begin
                    perf_hits_q <= perf_hits_q + 32'd1;
                end
                if (!lookup_hit && perf_misses_q != '1) begin
                    perf_misses_q <= perf_misses_q + 32'd1;
                end
            end
            if (tmo_expire && perf_timeouts_q != '1) begin
                perf_timeouts_q <= perf_timeouts_q + 16'd1;
            end
        end
    end

    assign perf_hits     = perf_hits_q;
    assign perf_misses   = perf_misses_q;
    assign perf_timeouts = perf_timeouts_q;
`endif

endmodule
